// File: rtl/tracker_pkg.sv
// Shared definitions for the entry-occupancy tracker.
package tracker_pkg;

    // Widest table the tracker is built for (256 entries).
    localparam int unsigned MAX_LOG_DEPTH = 8;
    localparam int unsigned MAX_DEPTH     = 1 << MAX_LOG_DEPTH;

    // One-hot decode of an entry index at the maximum table width; callers truncate.
    function automatic logic [MAX_DEPTH-1:0] onehot(input logic [MAX_LOG_DEPTH-1:0] idx);
        logic [MAX_DEPTH-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/first_zero_enc.sv
// Combinational priority encoder: index of the lowest clear bit of vec.
module first_zero_enc #(
    parameter int unsigned LOG_DEPTH = 4
) (
    input  logic [(1<<LOG_DEPTH)-1:0] vec,
    output logic [LOG_DEPTH-1:0]      idx,
    output logic                      none_found
);

    localparam int unsigned DEPTH = 1 << LOG_DEPTH;

    // Scan high to low so the lowest clear bit is the last one written.
    always_comb begin
        idx        = '0;
        none_found = 1'b1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!vec[i]) begin
                idx        = LOG_DEPTH'(i);
                none_found = 1'b0;
            end
        end
    end

endmodule

// File: rtl/valid_vec_tracker.sv
// Registered occupancy tracker for a table of 2**LOG_DEPTH entries: one alloc and one
// free per cycle, bulk flush, incremental population count and full/empty flags.
module valid_vec_tracker
    import tracker_pkg::*;
#(
    parameter int unsigned LOG_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   alloc_req,
    output logic                   alloc_gnt,
    output logic [LOG_DEPTH-1:0]   alloc_idx,
    input  logic                   free_vld,
    input  logic [LOG_DEPTH-1:0]   free_idx,
    input  logic                   flush,
    output logic [(1<<LOG_DEPTH)-1:0] valid_vec,
    output logic [LOG_DEPTH:0]     count,
    output logic                   full,
    output logic                   empty,
    output logic                   free_err
);

    localparam int unsigned DEPTH = 1 << LOG_DEPTH;
    localparam int unsigned CW    = LOG_DEPTH + 1;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             free_err_q, free_err_d;

    logic             none_found;
    logic             free_eff;
    logic [DEPTH-1:0] free_mask;
    logic [DEPTH-1:0] alloc_mask;

    first_zero_enc #(
        .LOG_DEPTH (LOG_DEPTH)
    ) u_first_zero_enc (
        .vec        (valid_q),
        .idx        (alloc_idx),
        .none_found (none_found)
    );

    // Grant depends only on registered state; none_found mirrors full_q by construction.
    always_comb begin
        alloc_gnt = alloc_req && !full_q && !none_found;
    end

    // Next-state: flush wins; otherwise apply free then alloc and track count incrementally.
    always_comb begin
        free_eff   = free_vld && valid_q[free_idx];
        free_mask  = DEPTH'(onehot(MAX_LOG_DEPTH'(free_idx)));
        alloc_mask = DEPTH'(onehot(MAX_LOG_DEPTH'(alloc_idx)));

        valid_d    = valid_q;
        count_d    = count_q;
        free_err_d = 1'b0;

        if (flush) begin
            valid_d = '0;
            count_d = '0;
        end else begin
            if (free_eff) begin
                valid_d = valid_d & ~free_mask;
            end
            if (alloc_gnt) begin
                valid_d = valid_d | alloc_mask;
            end
            count_d    = count_q + CW'(alloc_gnt) - CW'(free_eff);
            free_err_d = free_vld && !valid_q[free_idx];
        end

        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            valid_q    <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            free_err_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            free_err_q <= free_err_d;
        end
    end

    assign valid_vec = valid_q;
    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign free_err  = free_err_q;

endmodule

// File: tb/tb_valid_vec_tracker.sv
// Self-checking bench for valid_vec_tracker against an array-based occupancy model.
module tb_valid_vec_tracker;

    localparam int LOG_DEPTH = 4;
    localparam int DEPTH     = 1 << LOG_DEPTH;

    logic                 clk;
    logic                 resetN;
    logic                 alloc_req;
    logic                 alloc_gnt;
    logic [LOG_DEPTH-1:0] alloc_idx;
    logic                 free_vld;
    logic [LOG_DEPTH-1:0] free_idx;
    logic                 flush;
    logic [DEPTH-1:0]     valid_vec;
    logic [LOG_DEPTH:0]   count;
    logic                 full;
    logic                 empty;
    logic                 free_err;

    int n_vec;
    int n_err;

    // Model state: which entries are occupied, plus the pending error pulse.
    bit mv[DEPTH];
    bit m_err;

    valid_vec_tracker #(
        .LOG_DEPTH (LOG_DEPTH)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .alloc_req (alloc_req),
        .alloc_gnt (alloc_gnt),
        .alloc_idx (alloc_idx),
        .free_vld  (free_vld),
        .free_idx  (free_idx),
        .flush     (flush),
        .valid_vec (valid_vec),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .free_err  (free_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(mv[i]);
        return c;
    endfunction

    function automatic logic [31:0] model_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < DEPTH; i++) v[i] = mv[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        int c;
        c = model_count();
        check({tag, ".valid_vec"}, 32'(valid_vec), model_vec());
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".full"}, 32'(full), 32'(c == DEPTH));
        check({tag, ".empty"}, 32'(empty), 32'(c == 0));
        check({tag, ".free_err"}, 32'(free_err), 32'(m_err));
    endtask

    // One clock cycle: called just after a negedge, returns at the next negedge.
    task automatic step(input bit req, input bit fv, input int fi, input bit fl);
        int  lowest;
        bit  egnt;
        int  f;
        f         = fi % DEPTH;
        alloc_req = req;
        free_vld  = fv;
        free_idx  = LOG_DEPTH'(f);
        flush     = fl;
        #1;
        lowest = -1;
        for (int i = DEPTH - 1; i >= 0; i--) if (!mv[i]) lowest = i;
        egnt = req && (model_count() != DEPTH);
        check("alloc_gnt", 32'(alloc_gnt), 32'(egnt));
        check("alloc_idx", 32'(alloc_idx), (lowest < 0) ? 32'd0 : 32'(lowest));
        if (fl) begin
            model_clear();
        end else begin
            m_err = fv && !mv[f];
            if (fv && mv[f]) mv[f] = 1'b0;
            if (egnt) mv[lowest] = 1'b1;
        end
        @(posedge clk);
        #1;
        check_regs("cycle");
        @(negedge clk);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        resetN    = 1'b0;
        alloc_req = 1'b0;
        free_vld  = 1'b0;
        free_idx  = '0;
        flush     = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        check_regs("reset");
        resetN = 1'b1;

        // Fill the table in order, then a request when full must be refused.
        for (int i = 0; i < DEPTH; i++) begin
            check("fill_idx", 32'(alloc_idx), 32'(i));
            step(1, 0, 0, 0);
        end
        check("full_after_fill", 32'(full), 32'd1);
        step(1, 0, 0, 0);

        // Free while full, then simultaneous alloc and free.
        step(0, 1, 5, 0);
        check("refill_idx", 32'(alloc_idx), 32'd5);
        step(1, 1, 9, 0);
        check("swap_count", 32'(count), 32'd15);
        check("swap_bit5", 32'(valid_vec[5]), 32'd1);
        check("swap_bit9", 32'(valid_vec[9]), 32'd0);

        // Free of an invalid entry raises a one-cycle error pulse.
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("two_alloc_vec", 32'(valid_vec), 32'h0003);
        step(0, 1, 7, 0);
        check("err_pulse", 32'(free_err), 32'd1);
        step(0, 0, 0, 0);
        check("err_clear", 32'(free_err), 32'd0);

        // Flush outranks a concurrent alloc and free.
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 3, 1);
        check("flush_empty", 32'(empty), 32'd1);

        // Asynchronous reset between edges with eight entries held.
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
        check("pre_reset_count", 32'(count), 32'd8);
        #2;
        resetN = 1'b0;
        #1;
        model_clear();
        check_regs("async_reset");
        @(negedge clk);
        resetN = 1'b1;
        step(1, 0, 0, 0);

        // Random traffic in alternating fill-heavy and drain-heavy phases.
        for (int n = 0; n < 400; n++) begin
            bit fill_phase;
            fill_phase = ((n / 40) % 2) == 0;
            step(($urandom_range(0, 9) < (fill_phase ? 8 : 3)),
                 ($urandom_range(0, 9) < (fill_phase ? 3 : 8)),
                 int'($urandom_range(0, DEPTH - 1)),
                 ($urandom_range(0, 63) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
